// File: rtl/up_sampling_x2_pkg.sv
// Shared types and constants for the 2x nearest-neighbour upsampler.
// Defaults match the decoder stage behind up_sampling_7.
package up_sampling_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_STRING_LEN  = 7;
    localparam int DEF_LINE_NUM    = 7;
    localparam int DEF_CHANNEL_NUM = 3;

    localparam int LINE_WORDS     = DEF_STRING_LEN * DEF_CHANNEL_NUM;
    localparam int OUT_LINE_WORDS = 2 * LINE_WORDS;

    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int ADDR_W = addr_w(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT0,
        EMIT1
    } state_t;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
        logic sof;
        logic eof;
    } side_t;

endpackage

// File: rtl/up_sampling_x2_if.sv
// Pixel stream in/out bundle of the 2x upsampler.
// slave is the upsampler side, master is the neighbour/bench side.
interface up_sampling_x2_if #(
    parameter int DATA_WIDTH = 8
);
    logic signed [DATA_WIDTH-1:0] data_i;
    logic                         valid_i;
    logic                         ready_o;
    logic                         sop_i;
    logic                         eop_i;
    logic                         sof_i;
    logic                         eof_i;
    logic signed [DATA_WIDTH-1:0] data_o;
    logic                         data_valid_o;
    logic                         sop_o;
    logic                         eop_o;
    logic                         sof_o;
    logic                         eof_o;
    logic                         err_o;

    modport master (
        output data_i, valid_i, sop_i, eop_i, sof_i, eof_i,
        input  ready_o, data_o, data_valid_o,
        input  sop_o, eop_o, sof_o, eof_o, err_o
    );

    modport slave (
        input  data_i, valid_i, sop_i, eop_i, sof_i, eof_i,
        output ready_o, data_o, data_valid_o,
        output sop_o, eop_o, sof_o, eof_o, err_o
    );
endinterface

// File: rtl/up_sampling_x2_ram.sv
// Simple dual-port line RAM, one write and one registered read port.
// Contents are never reset.
module up_sampling_x2_ram #(
    parameter int    DATA_WIDTH = 8,
    parameter int    DEPTH      = 21,
    parameter int    ADDR_W     = 5,
    parameter string RAM_STYLE  = "M10K"
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] q_o
);
    (* ramstyle = RAM_STYLE *)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        q_q <= mem_q[raddr_i];
    end

    assign q_o = q_q;

endmodule

// File: rtl/up_sampling_x2.sv
// Nearest-neighbour 2x upsampler: load one line, replay it twice,
// each pixel (all channels) emitted twice per replay.
module up_sampling_x2
    import up_sampling_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int STRING_LEN  = DEF_STRING_LEN,
    parameter int LINE_NUM    = DEF_LINE_NUM,
    parameter int CHANNEL_NUM = DEF_CHANNEL_NUM
) (
    input  logic            clk,
    input  logic            reset_n,
    up_sampling_x2_if.slave port_if
);
    localparam int LW  = STRING_LEN * CHANNEL_NUM;
    localparam int AW  = addr_w(LW);
    localparam int LNW = $clog2(LINE_NUM) + 1;
    localparam int SW  = addr_w(2 * CHANNEL_NUM);

    localparam logic [AW-1:0]  LAST_ADDR = AW'(LW - 1);
    localparam logic [AW-1:0]  LAST_BASE = AW'(LW - CHANNEL_NUM);
    localparam logic [AW-1:0]  PIX_STEP  = AW'(CHANNEL_NUM);
    localparam logic [SW-1:0]  LAST_SUB  = SW'(2 * CHANNEL_NUM - 1);
    localparam logic [SW-1:0]  CH_NUM    = SW'(CHANNEL_NUM);
    localparam logic [LNW-1:0] LAST_LINE = LNW'(LINE_NUM - 1);

    state_t                state_q, state_d;
    logic [AW-1:0]         wcnt_q, wcnt_d;
    logic [LNW-1:0]        line_q, line_d;
    logic [AW-1:0]         base_q, base_d;
    logic [SW-1:0]         sub_q, sub_d;
    logic                  err_q, err_d;
    side_t                 s1_q, s1_d;
    side_t                 s2_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  rdy;
    logic                  acc;
    logic                  load_word;
    logic                  we;
    logic [AW-1:0]         wr_idx;
    logic [LNW-1:0]        ln;
    logic                  w_last;
    logic                  f_last;
    logic                  chk_err;
    logic                  e_first;
    logic                  e_last;
    logic [SW-1:0]         ch;
    logic [AW-1:0]         raddr;
    logic [DATA_WIDTH-1:0] rd_q;

    // sop_i is redundant: the word counter defines line starts
    logic unused_sop;
    assign unused_sop = port_if.sop_i;

    assign rdy = reset_n &&
                 (state_q == IDLE || state_q == LOAD);
    assign acc = port_if.valid_i && rdy;

    // a restarting sof_i word always lands at address 0 of line 0
    assign wr_idx = port_if.sof_i ? '0 : wcnt_q;
    assign ln     = port_if.sof_i ? '0 : line_q;
    assign w_last = (wr_idx == LAST_ADDR);
    assign f_last = w_last && (ln == LAST_LINE);

    assign chk_err = (port_if.eop_i != w_last) ||
                     (port_if.eof_i && !f_last);

    assign e_first = (base_q == '0) && (sub_q == '0);
    assign e_last  = (base_q == LAST_BASE) &&
                     (sub_q == LAST_SUB);

    assign ch    = (sub_q < CH_NUM) ? sub_q : sub_q - CH_NUM;
    assign raddr = base_q + AW'(ch);

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        line_d    = line_q;
        base_d    = base_q;
        sub_d     = sub_q;
        err_d     = err_q;
        s1_d      = '0;
        we        = 1'b0;
        load_word = 1'b0;

        unique case (state_q)
            IDLE: load_word = acc && port_if.sof_i;
            LOAD: load_word = acc;
            EMIT0, EMIT1: begin
                s1_d.valid = 1'b1;
                s1_d.sop   = e_first;
                s1_d.eop   = e_last;
                s1_d.sof   = e_first && (state_q == EMIT0) &&
                             (line_q == '0);
                s1_d.eof   = e_last && (state_q == EMIT1) &&
                             (line_q == LAST_LINE);
                if (sub_q == LAST_SUB) begin
                    sub_d  = '0;
                    base_d = base_q + PIX_STEP;
                end else begin
                    sub_d = sub_q + SW'(1);
                end
                if (e_last) begin
                    base_d = '0;
                    sub_d  = '0;
                    if (state_q == EMIT0) begin
                        state_d = EMIT1;
                    end else if (line_q == LAST_LINE) begin
                        state_d = IDLE;
                        line_d  = '0;
                    end else begin
                        state_d = LOAD;
                        line_d  = line_q + LNW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_word) begin
            we     = 1'b1;
            line_d = ln;
            err_d  = (port_if.sof_i ? 1'b0 : err_q) | chk_err;
            if (w_last) begin
                wcnt_d  = '0;
                state_d = EMIT0;
            end else begin
                wcnt_d  = wr_idx + AW'(1);
                state_d = LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            line_q  <= '0;
            base_q  <= '0;
            sub_q   <= '0;
            err_q   <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            line_q  <= line_d;
            base_q  <= base_d;
            sub_q   <= sub_d;
            err_q   <= err_d;
            s1_q    <= s1_d;
            s2_q    <= s1_q;
            data_q  <= s1_q.valid ? rd_q : '0;
        end
    end

    up_sampling_x2_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LW),
        .ADDR_W     (AW),
        .RAM_STYLE  ("M10K")
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_idx),
        .wdata_i (port_if.data_i),
        .raddr_i (raddr),
        .q_o     (rd_q)
    );

    assign port_if.ready_o      = rdy;
    assign port_if.data_o       = data_q;
    assign port_if.data_valid_o = s2_q.valid;
    assign port_if.sop_o        = s2_q.sop;
    assign port_if.eop_o        = s2_q.eop;
    assign port_if.sof_o        = s2_q.sof;
    assign port_if.eof_o        = s2_q.eof;
    assign port_if.err_o        = err_q;

endmodule
